instruction_fetch: RTL and testbench

Fetch stage directly upstream of `instruction_buffer`. Holds the program counter and issues one word-aligned request at a time to instruction memory over a valid/ready handshake. Pushes each returned instruction into the buffer via `write_en`/`data_in`, honours buffer `is_full` back-pressure, and handles branch redirects, including discarding a stale in-flight response. At most one request is outstanding; this guarantees the buffer cannot overflow.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/instruction_fetch.sv | 110 +++++++++++
 tb/tb_instruction_fetch.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  // Fetch controller states: idle, presenting a request, awaiting a wanted
  // response, awaiting a response that will be thrown away.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  // Bytes per instruction word; the PC advances by this much per fetch.
  localparam int INST_BYTES = 4;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues one word-aligned memory request
// at a time, forwards good responses straight into the instruction buffer and
// discards responses made stale by a redirect.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  input  logic                  imem_resp_err,
  input  logic                  buf_full,
  output logic                  buf_write_en,
  output logic [INST_WIDTH-1:0] buf_data,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  fetch_fault
);

  fetch_state_t          state, state_next;
  logic [ADDR_WIDTH-1:0] pc, pc_next;
  logic                  fault, fault_next;

  logic [ADDR_WIDTH-1:0] redirect_target;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  handshake;
  logic                  unused_redirect_low;

  // Redirect targets are forced to word alignment; the low bits are dropped.
  assign redirect_target     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign pc_inc              = pc + ADDR_WIDTH'(INST_BYTES);

  // A request is only offered when the buffer has room. Since only one
  // request can be outstanding and only its own response is ever written,
  // buf_full cannot rise while a request is being presented, so valid/addr
  // stay stable until the handshake or a redirect.
  assign imem_req_valid = (state == REQ) && !buf_full;
  assign imem_req_addr  = pc;
  assign handshake      = imem_req_valid && imem_req_ready;

  // Good responses go to the buffer in the same cycle they arrive.
  assign buf_write_en = (state == WAIT) && imem_resp_valid && !imem_resp_err && !redirect_valid;
  assign buf_data     = imem_resp_data;

  assign fetch_pc    = pc;
  assign fetch_fault = fault;

  // Next-state, PC and fault logic; a redirect overrides the PC and clears
  // the fault in every state.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    fault_next = fault;
    case (state)
      IDLE: begin
        if (redirect_valid || (fetch_en && !fault)) state_next = REQ;
      end
      REQ: begin
        // A redirect during the handshake makes the accepted request stale.
        if (handshake) state_next = redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        if (redirect_valid) begin
          state_next = imem_resp_valid ? REQ : DROP;
        end else if (imem_resp_valid) begin
          if (imem_resp_err) begin
            // Hold the faulting address in the PC for trap capture.
            fault_next = 1'b1;
            state_next = IDLE;
          end else begin
            pc_next    = pc_inc;
            state_next = fetch_en ? REQ : IDLE;
          end
        end
      end
      DROP: begin
        if (imem_resp_valid) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
    if (redirect_valid) begin
      pc_next    = redirect_target;
      fault_next = 1'b0;
    end
  end

  // State, PC and fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      fault <= fault_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized self-checking bench for instruction_fetch: a simple memory model
// answers accepted requests after a variable latency, and a transaction-level
// reference model predicts every output each cycle.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC  = 32'h0000_0100;
  localparam logic [31:0] NO_ADDR = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        imem_resp_err = 1'b0;
  logic        buf_full = 1'b0;
  logic        buf_write_en;
  logic [31:0] buf_data;
  logic [31:0] fetch_pc;
  logic        fetch_fault;

  instruction_fetch #(
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .buf_full       (buf_full),
    .buf_write_en   (buf_write_en),
    .buf_data       (buf_data),
    .fetch_pc       (fetch_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what the fetch unit owes the world.
  logic [31:0] m_pc;
  bit          m_fault;
  bit          m_want_req;   // a request should be offered to memory
  bit          m_pending;    // memory owes one response
  bit          m_unwanted;   // that owed response must be thrown away

  // Memory environment.
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  bit          mem_err;
  int          lat_lo = 0, lat_hi = 0, p_err = 0;
  logic [31:0] err_addr = NO_ADDR;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_data = '0;

  // Observations.
  logic [31:0] wr_log[$];
  logic [31:0] req_log[$];
  logic        last_v;
  logic [31:0] last_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + ((a - 32'h100) >> 2);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; buf_full = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_write_en", 32'(buf_write_en), 0);
    check("rst_fetch_pc", fetch_pc, RST_PC);
    check("rst_fault", 32'(fetch_fault), 0);
    m_pc = RST_PC; m_fault = 0; m_want_req = 0; m_pending = 0; m_unwanted = 0;
    mem_busy = 0; mem_cnt = 0; mem_addr = '0; mem_err = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model and the memory at the rising edge.
  task automatic cycle(input bit fe, input bit rdv, input logic [31:0] rdpc,
                       input bit rdy, input bit full);
    bit          exp_v, hs, resp, exp_wr;
    logic [31:0] old_pc;
    bit          was_idle;
    @(negedge clk);
    fetch_en = fe; redirect_valid = rdv; redirect_pc = rdpc;
    imem_req_ready = rdy; buf_full = full;
    imem_resp_valid = mem_busy && (mem_cnt == 0);
    imem_resp_data  = ovr_en ? ovr_data : mem_word(mem_addr);
    imem_resp_err   = imem_resp_valid && mem_err;
    #1;
    exp_v  = m_want_req && !full;
    hs     = exp_v && rdy;
    resp   = m_pending && imem_resp_valid;
    exp_wr = resp && !m_unwanted && !rdv && !imem_resp_err;
    check("req_valid", 32'(imem_req_valid), 32'(exp_v));
    if (exp_v) check("req_addr", imem_req_addr, m_pc);
    check("write_en", 32'(buf_write_en), 32'(exp_wr));
    if (exp_wr) check("buf_data", buf_data, imem_resp_data);
    check("fetch_pc", fetch_pc, m_pc);
    check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    last_v = imem_req_valid;
    last_a = imem_req_addr;
    if (buf_write_en) wr_log.push_back(buf_data);
    if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
    @(posedge clk);
    old_pc   = m_pc;
    was_idle = !m_want_req && !m_pending;
    if (resp) begin
      if (m_unwanted || rdv) m_want_req = 1;
      else if (imem_resp_err) begin m_fault = 1; m_want_req = 0; end
      else begin m_pc = m_pc + 32'd4; m_want_req = fe; end
      m_pending = 0; m_unwanted = 0;
    end else if (m_pending && rdv) begin
      m_unwanted = 1;
    end
    if (hs) begin m_pending = 1; m_want_req = 0; m_unwanted = rdv; end
    if (was_idle && (rdv || (fe && !m_fault))) m_want_req = 1;
    if (rdv) begin m_pc = {rdpc[31:2], 2'b00}; m_fault = 0; end
    if (imem_resp_valid) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (hs) begin
      mem_busy = 1;
      mem_addr = old_pc;
      mem_cnt  = int'($urandom_range(lat_hi, lat_lo));
      mem_err  = (old_pc == err_addr) || (int'($urandom_range(99)) < p_err);
    end
  endtask

  initial begin
    int n0;
    bit prev_rdv;
    do_reset();

    // Straight-line fetch from the reset PC with a 1-cycle memory.
    wr_log.delete(); req_log.delete();
    repeat (4) cycle(1, 0, '0, 1, 0);
    cycle(0, 0, '0, 1, 0);
    cycle(0, 0, '0, 1, 0);
    #1;
    check("a_pc", fetch_pc, 32'h108);
    check("a_wr_count", wr_log.size(), 2);
    check("a_wr0", wr_log[0], 32'hA0);
    check("a_wr1", wr_log[1], 32'hA1);
    check("a_req0", req_log[0], 32'h100);
    check("a_req1", req_log[1], 32'h104);

    // Buffer full holds the request back; the PC is unchanged when it issues.
    req_log.delete();
    cycle(1, 0, '0, 1, 1);
    repeat (3) begin
      cycle(1, 0, '0, 1, 1);
      check("b_held", 32'(last_v), 0);
    end
    cycle(1, 0, '0, 1, 0);
    cycle(0, 0, '0, 1, 0);
    check("b_req", req_log[0], 32'h108);

    // Memory not ready for 3 cycles: request stays put.
    req_log.delete();
    cycle(1, 0, '0, 0, 0);
    repeat (3) begin
      cycle(1, 0, '0, 0, 0);
      check("c_valid", 32'(last_v), 1);
      check("c_addr", last_a, 32'h10C);
    end
    cycle(1, 0, '0, 1, 0);
    cycle(0, 0, '0, 1, 0);
    check("c_req_count", req_log.size(), 1);

    // Redirect while waiting; the stale 0xDEAD response arrives later.
    lat_lo = 2; lat_hi = 2; ovr_en = 1; ovr_data = 32'hDEAD;
    cycle(1, 0, '0, 1, 0);
    cycle(1, 0, '0, 1, 0);
    n0 = wr_log.size();
    cycle(1, 1, 32'h203, 1, 0);
    cycle(1, 0, '0, 1, 0);
    cycle(1, 0, '0, 1, 0);
    check("d_no_write", wr_log.size(), n0);
    lat_lo = 0; lat_hi = 0; ovr_en = 0;
    cycle(1, 0, '0, 1, 0);
    cycle(0, 0, '0, 1, 0);
    check("d_req", req_log[$], 32'h200);
    check("d_wr", wr_log[$], 32'hE0);

    // Redirect in the same cycle as the response.
    cycle(1, 0, '0, 1, 0);
    cycle(1, 0, '0, 1, 0);
    n0 = wr_log.size();
    cycle(1, 1, 32'h300, 1, 0);
    check("e_no_write", wr_log.size(), n0);
    cycle(1, 0, '0, 1, 0);
    cycle(0, 0, '0, 1, 0);
    check("e_req", req_log[$], 32'h300);
    check("e_wr", wr_log[$], 32'h120);

    // Access fault, then recovery through a redirect.
    err_addr = 32'h110;
    cycle(0, 1, 32'h110, 1, 0);
    cycle(1, 0, '0, 1, 0);
    n0 = wr_log.size();
    repeat (4) cycle(1, 0, '0, 1, 0);
    #1;
    check("f_fault", 32'(fetch_fault), 1);
    check("f_pc", fetch_pc, 32'h110);
    check("f_no_write", wr_log.size(), n0);
    check("f_idle", 32'(last_v), 0);
    err_addr = NO_ADDR;
    cycle(1, 1, 32'h40, 1, 0);
    cycle(1, 0, '0, 1, 0);
    cycle(0, 0, '0, 1, 0);
    #1;
    check("f_fault_clr", 32'(fetch_fault), 0);
    check("f_req", req_log[$], 32'h40);

    // Randomized traffic, with one reset in the middle.
    lat_lo = 0; lat_hi = 3; p_err = 5;
    prev_rdv = 0;
    for (int i = 0; i < 2000; i++) begin
      bit          rdv;
      logic [31:0] tgt;
      if (i == 1000) begin
        do_reset();
        prev_rdv = 0;
      end
      rdv = !prev_rdv && ($urandom_range(99) < 8);
      tgt = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      cycle($urandom_range(99) < 85, rdv, tgt, $urandom_range(99) < 70, $urandom_range(99) < 20);
      prev_rdv = rdv;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
